// File: rtl/pe_multilayer_comp_fsm_if.sv
// Queue-side and datapath-side handshake bundle of the PE computation controller.
// The controller uses the master modport; the activation queue and MAC datapath use the slave modport.
interface pe_multilayer_comp_fsm_if #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int ACT_NO_W = 6
);
    logic                       queue_empty;
    logic [ADDR_W+DATA_W-1:0]   act_out;
    logic                       pop_act;
    logic                       comp_ready;
    logic                       comp_en;
    logic [ADDR_W-1:0]          in_act_idx;
    logic [DATA_W-1:0]          in_act_value;
    logic [ADDR_W-1:0]          out_act_idx;
    logic [ACT_NO_W-1:0]        out_act_addr;

    modport master (
        input  queue_empty, act_out, comp_ready,
        output pop_act, comp_en, in_act_idx, in_act_value, out_act_idx, out_act_addr
    );

    modport slave (
        output queue_empty, act_out, comp_ready,
        input  pop_act, comp_en, in_act_idx, in_act_value, out_act_idx, out_act_addr
    );
endinterface

// File: rtl/pe_multilayer_comp_fsm.sv
// Multi-layer PE compute controller: sweeps each queued activation over all local output slots.
// Optional macro PE_COMP_STAT_EN adds saturating busy/stall cycle counters.
module pe_multilayer_comp_fsm #(
    parameter int PE_IDX   = 0,
    parameter int PE_NUM   = 64,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int ACT_NO_W = 6,
    parameter int LAYER_W  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pe_start_calc_i,
    input  logic                fin_broadcast_i,
    input  logic                layer_done_i,
    input  logic [LAYER_W-1:0]  layer_no_i,
    input  logic [ACT_NO_W-1:0] out_act_no_i,
    output logic                out_act_clear_o,
    output logic                fin_comp_o,
    output logic                all_done_o,
    output logic [LAYER_W-1:0]  layer_idx_o,
`ifdef PE_COMP_STAT_EN
    output logic [31:0]         stat_busy_cycles_o,
    output logic [31:0]         stat_stall_cycles_o,
`endif
    pe_multilayer_comp_fsm_if.master bus
);
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_POST, S_SYNC} state_t;

    state_t              state_q, state_d;
    logic [ACT_NO_W-1:0] slot_q, slot_d;
    logic [LAYER_W-1:0]  layer_q, layer_d;
    logic                comp_en_q, comp_en_d;
    logic [ADDR_W-1:0]   in_idx_q, in_idx_d;
    logic [DATA_W-1:0]   in_val_q, in_val_d;
    logic [ADDR_W-1:0]   out_idx_q, out_idx_d;
    logic [ACT_NO_W-1:0] out_addr_q, out_addr_d;
    logic                clear_q, clear_d;
    logic                fin_q, fin_d;
    logic                done_q, done_d;

    logic [ACT_NO_W-1:0] last_slot;
    logic [LAYER_W-1:0]  last_layer;
    logic                issuing, fire, wrap;

    // A zero count is treated as one, so the last slot/layer index is 0 in that case.
    assign last_slot  = (out_act_no_i == '0) ? '0 : out_act_no_i - ACT_NO_W'(1);
    assign last_layer = (layer_no_i == '0) ? '0 : layer_no_i - LAYER_W'(1);
    assign issuing    = (state_q == S_PRE) || (state_q == S_POST);
    assign fire       = issuing && !bus.queue_empty && bus.comp_ready;
    assign wrap       = (slot_q == last_slot);
    assign bus.pop_act = fire && wrap;

    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        layer_d    = layer_q;
        comp_en_d  = 1'b0;
        in_idx_d   = in_idx_q;
        in_val_d   = in_val_q;
        out_idx_d  = out_idx_q;
        out_addr_d = out_addr_q;
        clear_d    = 1'b0;
        fin_d      = 1'b0;
        done_d     = 1'b0;

        if (fire) begin
            comp_en_d  = 1'b1;
            in_idx_d   = bus.act_out[ADDR_W+DATA_W-1:DATA_W];
            in_val_d   = bus.act_out[DATA_W-1:0];
            out_idx_d  = ADDR_W'(slot_q) * ADDR_W'(PE_NUM) + ADDR_W'(PE_IDX);
            out_addr_d = slot_q;
            slot_d     = wrap ? '0 : slot_q + ACT_NO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (pe_start_calc_i) begin
                    state_d = S_PRE;
                    layer_d = '0;
                    slot_d  = '0;
                    clear_d = 1'b1;
                end
            end
            S_PRE: begin
                // Broadcast completion is taken once, independent of datapath backpressure.
                if (fin_broadcast_i) state_d = S_POST;
            end
            S_POST: begin
                if (bus.queue_empty) begin
                    state_d = S_SYNC;
                    fin_d   = 1'b1;
                end
            end
            S_SYNC: begin
                if (layer_done_i) begin
                    if (layer_q == last_layer) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        layer_d = '0;
                    end else begin
                        state_d = S_PRE;
                        layer_d = layer_q + LAYER_W'(1);
                        slot_d  = '0;
                        clear_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            slot_q     <= '0;
            layer_q    <= '0;
            comp_en_q  <= 1'b0;
            in_idx_q   <= '0;
            in_val_q   <= '0;
            out_idx_q  <= '0;
            out_addr_q <= '0;
            clear_q    <= 1'b0;
            fin_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            slot_q     <= slot_d;
            layer_q    <= layer_d;
            comp_en_q  <= comp_en_d;
            in_idx_q   <= in_idx_d;
            in_val_q   <= in_val_d;
            out_idx_q  <= out_idx_d;
            out_addr_q <= out_addr_d;
            clear_q    <= clear_d;
            fin_q      <= fin_d;
            done_q     <= done_d;
        end
    end

    assign bus.comp_en      = comp_en_q;
    assign bus.in_act_idx   = in_idx_q;
    assign bus.in_act_value = in_val_q;
    assign bus.out_act_idx  = out_idx_q;
    assign bus.out_act_addr = out_addr_q;
    assign out_act_clear_o  = clear_q;
    assign fin_comp_o       = fin_q;
    assign all_done_o       = done_q;
    assign layer_idx_o      = layer_q;

`ifdef PE_COMP_STAT_EN
    logic [31:0] busy_q, stall_q;
    logic        stall;

    assign stall = issuing && !bus.queue_empty && !bus.comp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else if (state_q == S_IDLE && pe_start_calc_i) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (fire && busy_q != '1)   busy_q  <= busy_q + 32'd1;
            if (stall && stall_q != '1) stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_busy_cycles_o  = busy_q;
    assign stat_stall_cycles_o = stall_q;
`endif
endmodule

// File: tb/tb_pe_multilayer_comp_fsm.sv
// Directed bench for pe_multilayer_comp_fsm (PE_IDX=3, PE_NUM=64) with a small activation-queue model.
// Stat counter checks are compiled in when PE_COMP_STAT_EN is defined.
module tb_pe_multilayer_comp_fsm;
    logic        clk;
    logic        rst_n;
    logic        start, fb, ld;
    logic [3:0]  layer_no;
    logic [5:0]  out_act_no;
    logic        clear, fin, done;
    logic [3:0]  layer_idx;
`ifdef PE_COMP_STAT_EN
    logic [31:0] busy, stall;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] q_mem [0:7];
    int          q_head = 0;
    int          q_cnt  = 0;

    pe_multilayer_comp_fsm_if #(.ADDR_W(16), .DATA_W(16), .ACT_NO_W(6)) ifc ();

    pe_multilayer_comp_fsm #(
        .PE_IDX(3), .PE_NUM(64), .ADDR_W(16), .DATA_W(16), .ACT_NO_W(6), .LAYER_W(4)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .pe_start_calc_i     (start),
        .fin_broadcast_i     (fb),
        .layer_done_i        (ld),
        .layer_no_i          (layer_no),
        .out_act_no_i        (out_act_no),
        .out_act_clear_o     (clear),
        .fin_comp_o          (fin),
        .all_done_o          (done),
        .layer_idx_o         (layer_idx),
`ifdef PE_COMP_STAT_EN
        .stat_busy_cycles_o  (busy),
        .stat_stall_cycles_o (stall),
`endif
        .bus                 (ifc.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_q();
        ifc.queue_empty = (q_head >= q_cnt);
        ifc.act_out     = (q_head < q_cnt) ? q_mem[q_head] : 32'h0;
    endtask

    task automatic load_q(input int n, input logic [31:0] e0, input logic [31:0] e1);
        q_mem[0] = e0;
        q_mem[1] = e1;
        q_head   = 0;
        q_cnt    = n;
        drive_q();
    endtask

    // One clock: apply inputs, sample combinational pop, advance past the edge.
    task automatic cycle(input logic st, input logic rdy, input logic fb_in, input logic ld_in,
                         output logic popped);
        start          = st;
        ifc.comp_ready = rdy;
        fb             = fb_in;
        ld             = ld_in;
        drive_q();
        #1;
        popped = ifc.pop_act;
        @(posedge clk);
        #1;
        if (popped && q_head < q_cnt) q_head++;
        start = 1'b0;
        fb    = 1'b0;
        ld    = 1'b0;
        drive_q();
    endtask

    // Broadcast end with an empty queue, POST drain, then layer sync.
    task automatic finish_layer(input logic last, input logic [3:0] exp_idx);
        logic p;
        cycle(1'b0, 1'b1, 1'b1, 1'b0, p);
        n_vec++;
        if (ifc.comp_en !== 1'b0) begin
            n_err++;
            $display("FAIL fin_bcast_comp_en got=%b want=0", ifc.comp_en);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (fin !== 1'b1) begin
            n_err++;
            $display("FAIL fin_comp_pulse got=%b want=1", fin);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, p);
        n_vec++;
        if (fin !== 1'b0 || done !== last || clear !== !last || layer_idx !== exp_idx) begin
            n_err++;
            $display("FAIL layer_sync got fin=%b done=%b clr=%b lidx=%0d want fin=0 done=%b clr=%b lidx=%0d",
                     fin, done, clear, layer_idx, last, !last, exp_idx);
        end
    endtask

    task automatic test_reset();
        logic p;
        rst_n = 1'b0;
        start = 1'b1; fb = 1'b1; ld = 1'b1;
        ifc.comp_ready = 1'b1;
        layer_no = 4'd1; out_act_no = 6'd4;
        load_q(1, {16'h00AA, 16'h5555}, 32'h0);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (ifc.pop_act !== 1'b0 || ifc.comp_en !== 1'b0 || clear !== 1'b0 || fin !== 1'b0 ||
            done !== 1'b0 || layer_idx !== 4'd0 || ifc.in_act_idx !== 16'd0 ||
            ifc.in_act_value !== 16'd0 || ifc.out_act_idx !== 16'd0 || ifc.out_act_addr !== 6'd0) begin
            n_err++;
            $display("FAIL reset_outputs pop=%b en=%b clr=%b fin=%b done=%b lidx=%0d idx=%h val=%h oidx=%h addr=%0d want all 0",
                     ifc.pop_act, ifc.comp_en, clear, fin, done, layer_idx, ifc.in_act_idx,
                     ifc.in_act_value, ifc.out_act_idx, ifc.out_act_addr);
        end
        rst_n = 1'b1; start = 1'b0; fb = 1'b0; ld = 1'b0;
        @(posedge clk); #1;
        // Start a layer, issue once, then reset in the middle of it.
        cycle(1'b1, 1'b0, 1'b0, 1'b0, p);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (ifc.comp_en !== 1'b1) begin
            n_err++;
            $display("FAIL midreset_pre_fire got=%b want=1", ifc.comp_en);
        end
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (p !== 1'b0 || ifc.comp_en !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_release got pop=%b en=%b want pop=0 en=0", p, ifc.comp_en);
        end
        $display("reset: done");
    endtask

    task automatic test_basic();
        logic        p;
        logic [15:0] idx_tab [0:3];
        logic [15:0] exp_oidx, exp_iidx, exp_ival;
        logic [5:0]  exp_addr;
        idx_tab[0] = 16'd3; idx_tab[1] = 16'd67; idx_tab[2] = 16'd131; idx_tab[3] = 16'd195;
        layer_no = 4'd1; out_act_no = 6'd4;
        load_q(0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (clear !== 1'b1 || ifc.comp_en !== 1'b0) begin
            n_err++;
            $display("FAIL basic_start got clr=%b en=%b want clr=1 en=0", clear, ifc.comp_en);
        end
        load_q(2, {16'h0010, 16'h1111}, {16'h0020, 16'h2222});
        for (int k = 0; k < 8; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
            exp_oidx = idx_tab[k % 4];
            exp_addr = 6'(k % 4);
            exp_iidx = (k < 4) ? 16'h0010 : 16'h0020;
            exp_ival = (k < 4) ? 16'h1111 : 16'h2222;
            $display("basic fire %0d: pop=%b oidx=%0d addr=%0d in=%h/%h", k, p,
                     ifc.out_act_idx, ifc.out_act_addr, ifc.in_act_idx, ifc.in_act_value);
            n_vec++;
            if (p !== (k % 4 == 3) || ifc.comp_en !== 1'b1 || ifc.out_act_idx !== exp_oidx ||
                ifc.out_act_addr !== exp_addr || ifc.in_act_idx !== exp_iidx || ifc.in_act_value !== exp_ival) begin
                n_err++;
                $display("FAIL basic_fire%0d got pop=%b en=%b oidx=%0d addr=%0d in=%h/%h want pop=%b en=1 oidx=%0d addr=%0d in=%h/%h",
                         k, p, ifc.comp_en, ifc.out_act_idx, ifc.out_act_addr, ifc.in_act_idx,
                         ifc.in_act_value, (k % 4 == 3), exp_oidx, exp_addr, exp_iidx, exp_ival);
            end
        end
        finish_layer(1'b1, 4'd0);
    endtask

    task automatic test_backpressure();
        logic       p;
        logic       rdy_tab [0:3];
        logic [5:0] addr_tab [0:3];
        int         fires;
        rdy_tab[0] = 1'b1; rdy_tab[1] = 1'b0; rdy_tab[2] = 1'b0; rdy_tab[3] = 1'b1;
        addr_tab[0] = 6'd0; addr_tab[1] = 6'd0; addr_tab[2] = 6'd0; addr_tab[3] = 6'd1;
        layer_no = 4'd1; out_act_no = 6'd4;
        load_q(0, 32'h0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, p);
        load_q(1, {16'h0030, 16'h3333}, 32'h0);
        fires = 0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b0, rdy_tab[k], 1'b0, 1'b0, p);
            if (ifc.comp_en === 1'b1) fires++;
            $display("bp cycle %0d: rdy=%b en=%b addr=%0d", k, rdy_tab[k], ifc.comp_en, ifc.out_act_addr);
            n_vec++;
            if (p !== 1'b0 || ifc.comp_en !== rdy_tab[k] || ifc.out_act_addr !== addr_tab[k]) begin
                n_err++;
                $display("FAIL bp_cycle%0d got pop=%b en=%b addr=%0d want pop=0 en=%b addr=%0d",
                         k, p, ifc.comp_en, ifc.out_act_addr, rdy_tab[k], addr_tab[k]);
            end
        end
        n_vec++;
        if (fires != 2) begin
            n_err++;
            $display("FAIL bp_fire_count got=%0d want=2", fires);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (p !== 1'b1 || ifc.out_act_addr !== 6'd3 || ifc.out_act_idx !== 16'd195) begin
            n_err++;
            $display("FAIL bp_wrap got pop=%b addr=%0d oidx=%0d want pop=1 addr=3 oidx=195",
                     p, ifc.out_act_addr, ifc.out_act_idx);
        end
        finish_layer(1'b1, 4'd0);
    endtask

    task automatic test_layers();
        logic p;
        int   clears, dones;
        layer_no = 4'd3; out_act_no = 6'd0;
        load_q(0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, p);
        clears = (clear === 1'b1) ? 1 : 0;
        dones  = 0;
        n_vec++;
        if (clear !== 1'b1 || layer_idx !== 4'd0) begin
            n_err++;
            $display("FAIL layers_start got clr=%b lidx=%0d want clr=1 lidx=0", clear, layer_idx);
        end
        for (int l = 0; l < 3; l++) begin
            load_q(2, {16'(16'h0100 + l), 16'hB000}, {16'(16'h0200 + l), 16'hC000});
            // Broadcast end coincides with the first fire of the layer.
            cycle(1'b0, 1'b1, 1'b1, 1'b0, p);
            n_vec++;
            if (p !== 1'b1 || ifc.comp_en !== 1'b1 || ifc.out_act_addr !== 6'd0 ||
                ifc.out_act_idx !== 16'd3 || layer_idx !== 4'(l)) begin
                n_err++;
                $display("FAIL layer%0d_fire0 got pop=%b en=%b addr=%0d oidx=%0d lidx=%0d want pop=1 en=1 addr=0 oidx=3 lidx=%0d",
                         l, p, ifc.comp_en, ifc.out_act_addr, ifc.out_act_idx, layer_idx, l);
            end
            // Start request while busy must be ignored.
            cycle(1'b1, 1'b1, 1'b0, 1'b0, p);
            n_vec++;
            if (p !== 1'b1 || ifc.comp_en !== 1'b1 || ifc.in_act_idx !== 16'(16'h0200 + l) || clear !== 1'b0) begin
                n_err++;
                $display("FAIL layer%0d_fire1 got pop=%b en=%b idx=%h clr=%b want pop=1 en=1 idx=%h clr=0",
                         l, p, ifc.comp_en, ifc.in_act_idx, clear, 16'(16'h0200 + l));
            end
            cycle(1'b0, 1'b1, 1'b0, 1'b0, p);
            n_vec++;
            if (fin !== 1'b1 || ifc.comp_en !== 1'b0) begin
                n_err++;
                $display("FAIL layer%0d_fin got fin=%b en=%b want fin=1 en=0", l, fin, ifc.comp_en);
            end
            cycle(1'b0, 1'b1, 1'b0, 1'b1, p);
            if (clear === 1'b1) clears++;
            if (done === 1'b1) dones++;
            $display("layer %0d sync: lidx=%0d clr=%b done=%b", l, layer_idx, clear, done);
            n_vec++;
            if (done !== (l == 2) || layer_idx !== ((l == 2) ? 4'd0 : 4'(l + 1))) begin
                n_err++;
                $display("FAIL layer%0d_sync got done=%b lidx=%0d want done=%b lidx=%0d",
                         l, done, layer_idx, (l == 2), (l == 2) ? 0 : l + 1);
            end
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b1, p);
        if (done === 1'b1) dones++;
        n_vec++;
        if (clears != 3 || dones != 1) begin
            n_err++;
            $display("FAIL layers_pulse_count got clears=%0d dones=%0d want clears=3 dones=1", clears, dones);
        end
    endtask

`ifdef PE_COMP_STAT_EN
    task automatic test_stats();
        logic p;
        logic rdy_tab [0:7];
        rdy_tab[0] = 1'b1; rdy_tab[1] = 1'b0; rdy_tab[2] = 1'b1; rdy_tab[3] = 1'b0;
        rdy_tab[4] = 1'b1; rdy_tab[5] = 1'b0; rdy_tab[6] = 1'b1; rdy_tab[7] = 1'b1;
        layer_no = 4'd1; out_act_no = 6'd5;
        load_q(0, 32'h0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, p);
        n_vec++;
        if (busy !== 32'd0 || stall !== 32'd0) begin
            n_err++;
            $display("FAIL stats_clear got busy=%0d stall=%0d want 0/0", busy, stall);
        end
        load_q(1, {16'h0040, 16'h4444}, 32'h0);
        for (int k = 0; k < 8; k++) cycle(1'b0, rdy_tab[k], 1'b0, 1'b0, p);
        $display("stats: busy=%0d stall=%0d", busy, stall);
        n_vec++;
        if (busy !== 32'd5 || stall !== 32'd3 || p !== 1'b1) begin
            n_err++;
            $display("FAIL stats_count got busy=%0d stall=%0d lastpop=%b want busy=5 stall=3 lastpop=1",
                     busy, stall, p);
        end
        finish_layer(1'b1, 4'd0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_layers();
`ifdef PE_COMP_STAT_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
